// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// State codes, ALU op codes, opcode/funct values and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// R-type funct field to ALU operation; unknown funct reports invalid.
// Purely combinational, invalid encodings fall back to add.
module alu_func_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_op,
    output logic       o_valid
);

    always_comb begin
        o_alu_op = ALU_ADD;
        o_valid  = 1'b1;
        unique case (i_func)
            F_ADD, F_ADDU: o_alu_op = ALU_ADD;
            F_SUB, F_SUBU: o_alu_op = ALU_SUB;
            F_AND:         o_alu_op = ALU_AND;
            F_OR:          o_alu_op = ALU_OR;
            F_NOR:         o_alu_op = ALU_NOR;
            F_SLT:         o_alu_op = ALU_SLT;
            F_SRL:         o_alu_op = ALU_SRL;
            default:       o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM stepping the shared datapath through
// fetch, decode, execute, memory and write-back.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      w_c;
    logic [3:0] w_func_alu;
    logic       w_func_ok;

    alu_func_decode u_func_dec (
        .i_func   (func),
        .o_alu_op (w_func_alu),
        .o_valid  (w_func_ok)
    );

    // Async reset forces RESET, whose outputs are all zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_c      = '0;
        w_c.alu_op = ALU_ADD;
        case (r_state)
            S_RESET: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_c.mem_rd    = 1'b1;
                w_c.i_or_d    = 1'b0;
                w_c.alu_src_a = 1'b0;
                w_c.alu_src_b = SRCB_FOUR;
                w_c.pc_src    = PCSRC_ALU;
                w_c.ir_wr     = mem_ready;
                w_c.pc_wr     = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_c.alu_src_a = 1'b0;
                w_c.alu_src_b = SRCB_BR;
                w_c.ext_op    = 1'b1;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        if (is_imm_alu(op)) begin
                            w_next = S_I_EXEC;
                        end else begin
                            w_c.illegal    = 1'b1;
                            w_c.instr_done = 1'b1;
                            w_next         = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
                w_c.ext_op    = 1'b1;
                w_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_c.mem_rd = 1'b1;
                w_c.i_or_d = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_c.reg_wr     = 1'b1;
                w_c.mem_to_reg = 1'b1;
                w_c.reg_dst    = 1'b0;
                w_c.instr_done = 1'b1;
                w_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_c.mem_wr = 1'b1;
                w_c.i_or_d = 1'b1;
                if (mem_ready) begin
                    w_c.instr_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_R_EXEC: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_RT;
                w_c.alu_op    = w_func_alu;
                if (w_func_ok) begin
                    w_next = S_R_WB;
                end else begin
                    w_c.illegal    = 1'b1;
                    w_c.instr_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_R_WB: begin
                w_c.reg_wr     = 1'b1;
                w_c.reg_dst    = 1'b1;
                w_c.mem_to_reg = 1'b0;
                w_c.instr_done = 1'b1;
                w_next = S_FETCH;
            end
            S_I_EXEC: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
                if (op == OP_ORI) begin
                    w_c.ext_op = 1'b0;
                    w_c.alu_op = ALU_OR;
                end else begin
                    w_c.ext_op = 1'b1;
                    w_c.alu_op = ALU_ADD;
                end
                w_next = S_I_WB;
            end
            S_I_WB: begin
                w_c.reg_wr     = 1'b1;
                w_c.reg_dst    = 1'b0;
                w_c.mem_to_reg = 1'b0;
                w_c.instr_done = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_c.alu_src_a  = 1'b1;
                w_c.alu_src_b  = SRCB_RT;
                w_c.alu_op     = ALU_SUB;
                w_c.pc_wr_cond = 1'b1;
                w_c.pc_src     = PCSRC_ALUOUT;
                w_c.instr_done = 1'b1;
                w_next = S_FETCH;
            end
            S_JUMP: begin
                w_c.pc_wr      = 1'b1;
                w_c.pc_src     = PCSRC_JUMP;
                w_c.instr_done = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

    assign pc_wr      = w_c.pc_wr;
    assign pc_wr_cond = w_c.pc_wr_cond;
    assign pc_src     = w_c.pc_src;
    assign ir_wr      = w_c.ir_wr;
    assign i_or_d     = w_c.i_or_d;
    assign mem_rd     = w_c.mem_rd;
    assign mem_wr     = w_c.mem_wr;
    assign reg_wr     = w_c.reg_wr;
    assign reg_dst    = w_c.reg_dst;
    assign mem_to_reg = w_c.mem_to_reg;
    assign alu_src_a  = w_c.alu_src_a;
    assign alu_src_b  = w_c.alu_src_b;
    assign ext_op     = w_c.ext_op;
    assign alu_op     = w_c.alu_op;
    assign instr_done = w_c.instr_done;
    assign illegal    = w_c.illegal;
    assign state      = r_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset CPU. It replaces per-instruction combinational control with a Moore/Mealy FSM that steps the shared datapath through fetch, decode, execute, memory and write-back. The shared datapath is one ALU, one unified memory port, IR, ALUOut, MDR and the register file. The block sits between the instruction register (op/funct fields) and the datapath mux/enable inputs, and handshakes with the memory port through `mem_ready`.

## Interface
- No parameters; all widths fixed by the ISA.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: IR[31:26]; stable from the cycle after IR write.
- `func` in 6: IR[5:0].
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_wr` out 1: unconditional PC write.
- `pc_wr_cond` out 1: PC write if ALU zero; datapath ANDs with zero.
- `pc_src` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `ir_wr` out 1: IR load enable.
- `i_or_d` out 1: memory address 0 = PC, 1 = ALUOut.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `reg_wr` out 1: register file write.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALUOut.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2.
- `ext_op` out 1: 1 = sign-extend, 0 = zero-extend.
- `alu_op` out 4: 0000 add, 0001 sub, 0011 or, 0100 and, 0101 slt, 0110 nor, 1000 srl.
- `instr_done` out 1: one-cycle pulse in the final state of every instruction.
- `illegal` out 1: one-cycle pulse on unsupported op or funct.
- `state` out 4: current state encoding, for debug.

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Every output not listed for a state is 0, except `alu_op`, which defaults to add.
- RESET: all outputs 0. Goes unconditionally to FETCH.
- FETCH: `mem_rd`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00.
  - `ir_wr` and `pc_wr` = `mem_ready` (Mealy outputs).
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `ext_op`=1, add (branch target into ALUOut). Next state by `op`:
  - 100011 (lw) / 101011 (sw) → MEM_ADDR
  - 000000 → R_EXEC
  - 001000 / 001001 / 001101 → I_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - anything else → FETCH with `illegal`=1 and `instr_done`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ext_op`=1, add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_rd`=1, `i_or_d`=1. Waits for `mem_ready`, then MEM_WB.
- MEM_WB: `reg_wr`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Then FETCH.
- MEM_WR: `mem_wr`=1, `i_or_d`=1. Waits for `mem_ready`; when it arrives, `instr_done`=1 and next is FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct:
  - 100000 / 100001 → add; 100010 / 100011 → sub; 100100 → and; 100101 → or; 100111 → nor; 101010 → slt; 000010 → srl.
  - Supported funct → R_WB.
  - Unknown funct → FETCH with `illegal`=1 and `instr_done`=1; no register write.
- R_WB: `reg_wr`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Then FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10.
  - `ext_op`=1 and add for addi/addiu.
  - `ext_op`=0 and or for ori.
  - Then I_WB.
- I_WB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_wr_cond`=1, `pc_src`=01, `instr_done`=1. Then FETCH.
- JUMP: `pc_wr`=1, `pc_src`=10, `instr_done`=1. Then FETCH.

## Timing
- Instruction latency with zero-wait memory (FETCH sees `mem_ready` in its first cycle):
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, j: 3 cycles
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_rd`/`mem_wr` stay asserted and stable while waiting. No other strobe toggles during a wait.
- `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
- `rst` asserted at any time (including mid-wait): state immediately becomes RESET and all outputs go to 0 asynchronously.
- After deassertion: first clock → FETCH, so the first fetch strobe appears in the second cycle.
- `instr_done` never asserts in consecutive cycles.

## Structure
- Package `mc_ctrl_pkg`: state enum (4-bit), ALU op codes, opcode and funct localparams, `alu_src_b`/`pc_src` encodings.
- Sub-module `alu_func_decode`: funct → {`alu_op`, `valid`}, purely combinational. It is instantiated once and used in R_EXEC.
- The state register is the only sequential element.

## Test plan
- Reset mid-MEM_RD:
  - Stimulus: `rst` pulse while in MEM_RD waiting.
  - Response: `state`=RESET and all outputs 0 in the same cycle; `mem_rd` first reasserts in the second cycle after release.
- lw with `mem_ready` held high:
  - State sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB.
  - `reg_wr`=`mem_to_reg`=1 in cycle 5 only.
  - `instr_done` once.
- sw with `mem_ready` low for 3 cycles in MEM_WR:
  - `mem_wr`=1 and `i_or_d`=1 for 4 cycles.
  - Total 7 cycles.
- R-type funct 100111:
  - Response: `alu_op`=0110 in R_EXEC, then `reg_dst`=1, `reg_wr`=1.
- Illegal encodings:
  - Stimulus: op=111111 in DECODE → `illegal`=1 and `instr_done`=1 for one cycle, then FETCH, no write strobes.
  - Stimulus: R-type funct 001000 → same response from R_EXEC.
- Control-flow instructions:
  - ori: `ext_op`=0, `alu_op`=0011.
  - beq: `pc_wr_cond`=1, `pc_src`=01, `alu_op`=0001 in cycle 3.
  - j: `pc_wr`=1, `pc_src`=10 in cycle 3.
